// File: rtl/video_pkg.sv
// Shared types and constants for the packed-24bpp video receive path.
package video_pkg;

    // One unpacked pixel, red in the top byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int PIX_BYTES       = 3;
    localparam int WORDS_PER_GROUP = 3;
    localparam int PIX_PER_GROUP   = 4;
    localparam int BUF_BYTES       = 6;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    // Bit positions inside err_flags.
    typedef enum logic [1:0] {
        ERR_SHORT = 2'd0,
        ERR_LONG  = 2'd1,
        ERR_SOF   = 2'd2,
        ERR_KEEP  = 2'd3
    } err_idx_e;

    // Frame-level state: dropping words until a tuser word arrives, or inside a frame.
    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_IN_FRAME = 1'b1
    } sof_state_e;

endpackage

// File: rtl/rgb_byte_unpacker.sv
// Six-byte reassembly buffer: takes 32-bit words of packed 24bpp bytes and
// presents the oldest three bytes as one pixel, carrying the SOF/EOL word tags.
//
// Handshakes: a word moves when wr_en is high (the caller only raises it on
// tvalid & wr_ready); a pixel moves when pix_valid & pix_ready at a rising edge.
// wr_ready is registered as (cnt <= 2) and pix_valid is (cnt >= 3), so the two
// sides never move in the same cycle; a 3-word group takes 7 cycles to pass.
module rgb_byte_unpacker
    import video_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_sof,
    input  logic        wr_eol,
    output logic        wr_ready,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix,
    output logic        pix_sof,
    output logic        pix_eol_tag
);

    logic [7:0]           byte_q [BUF_BYTES];
    logic [7:0]           byte_d [BUF_BYTES];
    logic [BUF_BYTES-1:0] sof_q, sof_d;
    logic [BUF_BYTES-1:0] eol_q, eol_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           base;
    logic [2:0]           eol_pos;
    logic                 ready_q;
    logic                 emit;

    assign pix_valid   = (cnt_q >= 3'd3);
    assign emit        = pix_valid & pix_ready;
    assign wr_ready    = ready_q;
    assign pix         = {byte_q[2], byte_q[1], byte_q[0]};
    assign pix_sof     = sof_q[0];
    assign pix_eol_tag = eol_q[2];

    // Next buffer contents: drop the emitted pixel, then append the accepted word.
    // Pixel boundaries always sit at index 0 and 3, so the line-end tag goes on
    // the final byte of the last pixel the word completes (index 2, or 5 when
    // the word starts at index 2).
    always_comb begin
        byte_d  = byte_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        base    = cnt_q;
        cnt_d   = cnt_q;
        eol_pos = 3'd2;
        if (emit) begin
            for (int i = 0; i < BUF_BYTES - PIX_BYTES; i++) begin
                byte_d[i] = byte_q[i + PIX_BYTES];
                sof_d[i]  = sof_q[i + PIX_BYTES];
                eol_d[i]  = eol_q[i + PIX_BYTES];
            end
            for (int i = BUF_BYTES - PIX_BYTES; i < BUF_BYTES; i++) begin
                byte_d[i] = 8'h00;
                sof_d[i]  = 1'b0;
                eol_d[i]  = 1'b0;
            end
            base = cnt_q - 3'(PIX_BYTES);
        end
        eol_pos = (base == 3'd2) ? 3'd5 : 3'd2;
        cnt_d   = base;
        if (wr_en) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                if (i >= int'(base) && i < int'(base) + 4) begin
                    byte_d[i] = wr_data[8*(i - int'(base)) +: 8];
                    sof_d[i]  = wr_sof && (i == int'(base));
                    eol_d[i]  = wr_eol && (i == int'(eol_pos));
                end
            end
            cnt_d = base + 3'd4;
        end
    end

    // Buffer, fill count and registered ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                byte_q[i] <= 8'h00;
            end
            sof_q   <= '0;
            eol_q   <= '0;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d <= 3'd2);
        end
    end

endmodule

// File: rtl/video_stream_unpacker.sv
// AXI-Stream video sink: unpacks 24bpp words into one pixel per beat, tracks
// x/y against tuser/tlast, counts frames and latches geometry errors.
module video_stream_unpacker
    import video_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             out_stream_aclk,
    input  logic             periph_resetn,
    input  logic [31:0]      in_stream_tdata,
    input  logic [3:0]       in_stream_tkeep,
    input  logic             in_stream_tuser,
    input  logic             in_stream_tlast,
    input  logic             in_stream_tvalid,
    output logic             in_stream_tready,
    output logic [7:0]       pix_r,
    output logic [7:0]       pix_g,
    output logic [7:0]       pix_b,
    output logic [9:0]       pix_x,
    output logic [8:0]       pix_y,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [3:0]       err_flags,
    input  logic             err_clr
);

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    sof_state_e       state_q, state_d;
    logic             acc, emit, wr_en, early_sof;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             line_adv, frame_end;
    logic [3:0]       err_q, err_set;
    logic             frame_done_q;
    logic [CNT_W-1:0] frame_count_q;
    logic [23:0]      pix_word;
    logic             pix_eol_tag;
    rgb_t             pix;

    assign acc       = in_stream_tvalid & in_stream_tready;
    assign emit      = pix_valid & pix_ready;
    // Words before the first tuser are consumed but never reach the buffer.
    assign wr_en     = acc & (in_stream_tuser | (state_q == ST_IN_FRAME));
    assign early_sof = acc & in_stream_tuser & (state_q == ST_IN_FRAME);

    rgb_byte_unpacker u_unpack (
        .aclk        (out_stream_aclk),
        .aresetn     (periph_resetn),
        .wr_en       (wr_en),
        .wr_data     (in_stream_tdata),
        .wr_sof      (in_stream_tuser),
        .wr_eol      (in_stream_tlast),
        .wr_ready    (in_stream_tready),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix         (pix_word),
        .pix_sof     (pix_sof),
        .pix_eol_tag (pix_eol_tag)
    );

    assign pix         = rgb_t'(pix_word);
    assign pix_r       = pix.r;
    assign pix_g       = pix.g;
    assign pix_b       = pix.b;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_eol     = (x_q == X_LAST);
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_flags   = err_q;

    // Geometry advance on each emitted pixel, tlast/tuser resync, error detection.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        line_adv  = 1'b0;
        frame_end = 1'b0;
        err_set   = 4'b0000;
        if (emit) begin
            if (x_q == X_LAST) begin
                line_adv = 1'b1;
                if (!pix_eol_tag) err_set[ERR_LONG] = 1'b1;
            end else if (pix_eol_tag) begin
                line_adv = 1'b1;
                err_set[ERR_SHORT] = 1'b1;
            end
            if (line_adv) begin
                x_d = 10'd0;
                if (y_q == Y_LAST) begin
                    y_d       = 9'd0;
                    frame_end = 1'b1;
                end else begin
                    y_d = y_q + 9'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        if (early_sof) begin
            x_d = 10'd0;
            y_d = 9'd0;
            err_set[ERR_SOF] = 1'b1;
        end
        if (acc && (in_stream_tkeep != 4'hF)) err_set[ERR_KEEP] = 1'b1;
    end

    // Frame state next-state: leave WAIT_SOF on a tuser word, return after the last line.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_SOF: if (acc && in_stream_tuser) state_d = ST_IN_FRAME;
            ST_IN_FRAME: if (frame_end) state_d = ST_WAIT_SOF;
        endcase
    end

    // Registers for frame state, counters and sticky errors (a new error beats err_clr).
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q       <= ST_WAIT_SOF;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
            err_q         <= 4'b0000;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            err_q         <= (err_clr ? 4'b0000 : err_q) | err_set;
            frame_done_q  <= frame_end;
            frame_count_q <= frame_count_q + CNT_W'(frame_end);
        end
    end

endmodule
